// File: rtl/raster_to_block_pkg.sv
// Shared types and constants for the raster-to-8x8-block reorder path.
// dctPort_t is the pixel stream type used throughout the DCT front end.
package raster_to_block_pkg;

    localparam int BLOCK_N = 8;
    localparam int PIX_W   = 24;

    typedef struct packed {
        logic             valid;
        logic [PIX_W-1:0] data;
    } dctPort_t;

    typedef enum logic {
        IDLE,
        READ
    } readState_t;

endpackage

// File: rtl/raster_to_block_line_buf_ram.sv
// Simple dual-port band buffer: one write port, one registered read port.
// The read register only loads on rd_en so the last pixel stays on the output.
module line_buf_ram
    import raster_to_block_pkg::*;
#(
    parameter int DEPTH = 2 * BLOCK_N * 1280,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             pclk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [PIX_W-1:0] rd_data
);

    logic [PIX_W-1:0] mem [DEPTH];

    always_ff @(posedge pclk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge pclk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/raster_to_block.sv
// Reorders a raster pixel stream into 8x8 block order using a ping-pong
// pair of 8-line band buffers; one band is read out while the next fills.
module raster_to_block
    import raster_to_block_pkg::*;
#(
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 720
) (
    input  logic     pclk,
    input  logic     rst,
    input  dctPort_t in,
    output dctPort_t out,
    output logic     blkFirst,
    output logic     blkLast,
    output logic     frameLast,
    output logic     overflow
);

    localparam int BAND_PIX = BLOCK_N * WIDTH;
    localparam int DEPTH    = 2 * BAND_PIX;
    localparam int AW       = $clog2(DEPTH);
    localparam int COL_W    = $clog2(WIDTH);
    localparam int LINE_W   = $clog2(HEIGHT);
    localparam int BLKS     = WIDTH / BLOCK_N;
    localparam int BX_W     = (BLKS > 1) ? $clog2(BLKS) : 1;

    // Write side
    logic [COL_W-1:0]  col_reg;
    logic [2:0]        row_reg;
    logic [LINE_W-1:0] line_reg;
    logic              wr_bank_reg;
    logic              band_ready;
    logic [AW-1:0]     wr_addr;

    assign band_ready = in.valid && (row_reg == 3'd7) && (col_reg == COL_W'(WIDTH - 1));
    assign wr_addr    = (wr_bank_reg ? AW'(BAND_PIX) : '0)
                      + AW'(row_reg) * AW'(WIDTH) + AW'(col_reg);

    always_ff @(posedge pclk) begin
        if (rst) begin
            col_reg     <= '0;
            row_reg     <= '0;
            line_reg    <= '0;
            wr_bank_reg <= 1'b0;
        end else if (in.valid) begin
            if (col_reg == COL_W'(WIDTH - 1)) begin
                col_reg  <= '0;
                row_reg  <= row_reg + 3'd1;
                line_reg <= (line_reg == LINE_W'(HEIGHT - 1)) ? '0 : line_reg + LINE_W'(1);
                if (row_reg == 3'd7) begin
                    wr_bank_reg <= ~wr_bank_reg;
                end
            end else begin
                col_reg <= col_reg + COL_W'(1);
            end
        end
    end

    // Read side
    readState_t       state_reg, state_next;
    logic [2:0]       rc_reg, rr_reg;
    logic [BX_W-1:0]  bx_reg;
    logic             rd_bank_reg;
    logic             last_band_reg;
    logic             rd_en;
    logic             rd_last;
    logic [AW-1:0]    rd_addr;
    logic [PIX_W-1:0] rd_data;

    assign rd_en   = (state_reg == READ);
    assign rd_last = (rc_reg == 3'd7) && (rr_reg == 3'd7) && (bx_reg == BX_W'(BLKS - 1));
    assign rd_addr = (rd_bank_reg ? AW'(BAND_PIX) : '0)
                   + AW'(rr_reg) * AW'(WIDTH) + AW'(bx_reg) * AW'(BLOCK_N) + AW'(rc_reg);

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (band_ready) state_next = READ;
            READ:    if (rd_last)    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A band completing mid-read is dropped: only IDLE latches bank and tag.
    always_ff @(posedge pclk) begin
        if (rst) begin
            rd_bank_reg   <= 1'b0;
            last_band_reg <= 1'b0;
            overflow      <= 1'b0;
        end else if (band_ready) begin
            if (state_reg == IDLE) begin
                rd_bank_reg   <= wr_bank_reg;
                last_band_reg <= (line_reg == LINE_W'(HEIGHT - 1));
            end else begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            rc_reg <= '0;
            rr_reg <= '0;
            bx_reg <= '0;
        end else if (rd_en) begin
            rc_reg <= rc_reg + 3'd1;
            if (rc_reg == 3'd7) begin
                rr_reg <= rr_reg + 3'd1;
                if (rr_reg == 3'd7) begin
                    bx_reg <= (bx_reg == BX_W'(BLKS - 1)) ? '0 : bx_reg + BX_W'(1);
                end
            end
        end
    end

    // Flags are registered alongside the RAM read so they line up with data.
    logic valid_reg;
    logic hold_zero_reg;

    always_ff @(posedge pclk) begin
        if (rst) begin
            valid_reg     <= 1'b0;
            blkFirst      <= 1'b0;
            blkLast       <= 1'b0;
            frameLast     <= 1'b0;
            hold_zero_reg <= 1'b1;
        end else begin
            valid_reg <= rd_en;
            blkFirst  <= rd_en && (rr_reg == 3'd0) && (rc_reg == 3'd0);
            blkLast   <= rd_en && (rr_reg == 3'd7) && (rc_reg == 3'd7);
            frameLast <= rd_en && rd_last && last_band_reg;
            if (rd_en) begin
                hold_zero_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        out.valid = valid_reg;
        out.data  = hold_zero_reg ? '0 : rd_data;
    end

    line_buf_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .pclk    (pclk),
        .wr_en   (in.valid),
        .wr_addr (wr_addr),
        .wr_data (in.data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_raster_to_block.sv
// Directed bench for raster_to_block at WIDTH=16, HEIGHT=16.
module tb_raster_to_block;
    import raster_to_block_pkg::*;

    localparam int W = 16;
    localparam int H = 16;

    logic     pclk = 1'b0;
    logic     rst  = 1'b1;
    dctPort_t in_s;
    dctPort_t out_s;
    logic     blk_first, blk_last, frame_last, overflow;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    logic [23:0] dq[$];
    bit          fq[$];
    bit          lq[$];
    bit          flq[$];
    int          cq[$];

    raster_to_block #(.WIDTH(W), .HEIGHT(H)) dut (
        .pclk      (pclk),
        .rst       (rst),
        .in        (in_s),
        .out       (out_s),
        .blkFirst  (blk_first),
        .blkLast   (blk_last),
        .frameLast (frame_last),
        .overflow  (overflow)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    always @(negedge pclk) begin
        if (!rst && out_s.valid) begin
            dq.push_back(out_s.data);
            fq.push_back(blk_first);
            lq.push_back(blk_last);
            flq.push_back(frame_last);
            cq.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Raster index (line*16+col) of block-order output j within one frame.
    function automatic int exp_k(input int j);
        int band, m, bx, r, c;
        band = j / 128;
        m    = j % 128;
        bx   = m / 64;
        r    = (m % 64) / 8;
        c    = m % 8;
        return (band * 8 + r) * W + bx * 8 + c;
    endfunction

    task automatic px(input logic [23:0] v, output int c);
        @(posedge pclk);
        #1;
        in_s.valid = 1'b1;
        in_s.data  = v;
        c = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
            in_s.valid = 1'b0;
        end
    endtask

    task automatic do_reset(input string tag);
        @(posedge pclk);
        #1;
        rst        = 1'b1;
        in_s.valid = 1'b0;
        @(posedge pclk);
        @(negedge pclk);
        chk({tag, "_rst_valid"}, {31'd0, out_s.valid}, 32'd0);
        chk({tag, "_rst_flags"}, {28'd0, blk_first, blk_last, frame_last, overflow}, 32'd0);
        chk({tag, "_rst_data"}, {8'd0, out_s.data}, 32'd0);
        @(posedge pclk);
        #1;
        rst = 1'b0;
        dq.delete(); fq.delete(); lq.delete(); flq.delete(); cq.delete();
    endtask

    // Compares a captured burst against the raster model; base1 applies to frame 2.
    task automatic check_burst(input string tag, input int n_exp, input int base0, input int base1);
        int derr, ferr, gerr, n;
        derr = 0; ferr = 0; gerr = 0;
        n = (dq.size() < n_exp) ? dq.size() : n_exp;
        chk({tag, "_count"}, dq.size(), n_exp);
        for (int i = 0; i < n; i++) begin
            if (dq[i] !== 24'((i < 256 ? base0 : base1) + exp_k(i % 256))) derr++;
            if (fq[i] != (i % 64 == 0)) ferr++;
            if (lq[i] != (i % 64 == 63)) ferr++;
            if (flq[i] != (i % 256 == 255)) ferr++;
            if ((i % 128 != 127) && (i + 1 < n) && (cq[i + 1] != cq[i] + 1)) gerr++;
        end
        chk({tag, "_data_errs"}, derr, 0);
        chk({tag, "_flag_errs"}, ferr, 0);
        chk({tag, "_gap_errs"}, gerr, 0);
        $display("%s: %0d outputs captured", tag, dq.size());
    endtask

    initial begin
        int wc, wc128, nfl;
        in_s = '0;
        repeat (3) @(posedge pclk);
        do_reset("init");

        // Dense band, pixel value = line*16+col
        for (int k = 0; k < 128; k++) px(24'(k), wc);
        idle(140);
        check_burst("A", 128, 0, 0);
        if (dq.size() >= 128) begin
            chk("A_out0", {8'd0, dq[0]}, 32'd0);
            chk("A_out7", {8'd0, dq[7]}, 32'd7);
            chk("A_out9", {8'd0, dq[8]}, 32'd16);
            chk("A_out64", {8'd0, dq[63]}, 32'd119);
            chk("A_out65", {8'd0, dq[64]}, 32'd8);
            chk("A_first65", {31'd0, fq[64]}, 32'd1);
            chk("A_last128", {31'd0, lq[127]}, 32'd1);
        end
        chk("A_ovf", {31'd0, overflow}, 32'd0);

        // Full frame at 1-in-3 input rate
        do_reset("B");
        wc128 = 0;
        for (int k = 0; k < 256; k++) begin
            px(24'h100000 + 24'(k), wc);
            if (k == 127) wc128 = wc;
            idle(2);
        end
        idle(140);
        check_burst("B", 256, 24'h100000, 24'h100000);
        if (cq.size() > 0) chk("B_latency", cq[0] - wc128, 32'd2);
        nfl = 0;
        foreach (flq[i]) if (flq[i]) nfl++;
        chk("B_framelast_n", nfl, 1);
        chk("B_ovf", {31'd0, overflow}, 32'd0);

        // Two consecutive frames, no reset in between
        dq.delete(); fq.delete(); lq.delete(); flq.delete(); cq.delete();
        for (int k = 0; k < 512; k++) begin
            px((k < 256 ? 24'h200000 : 24'h300000) + 24'(k % 256), wc);
            idle(2);
        end
        idle(140);
        check_burst("C", 512, 24'h200000, 24'h300000);
        nfl = 0;
        foreach (flq[i]) if (flq[i]) nfl++;
        chk("C_framelast_n", nfl, 2);
        if (dq.size() > 256) chk("C_f2_px0", {8'd0, dq[256]}, 32'h300000);
        chk("C_ovf", {31'd0, overflow}, 32'd0);

        // Back-to-back dense bands: second completes while the first is read
        do_reset("D");
        for (int k = 0; k < 256; k++) begin
            px(24'h400000 + 24'(k), wc);
            if (k == 200) begin
                @(negedge pclk);
                chk("D_ovf_pre", {31'd0, overflow}, 32'd0);
            end
        end
        idle(2);
        chk("D_ovf_set", {31'd0, overflow}, 32'd1);
        idle(200);
        chk("D_ovf_sticky", {31'd0, overflow}, 32'd1);
        check_burst("D", 128, 24'h400000, 24'h400000);

        // Reset part-way through a band, then a fresh band
        do_reset("E0");
        for (int k = 0; k < 70; k++) px(24'h500000 + 24'(k), wc);
        do_reset("E");
        wc128 = 0;
        for (int k = 0; k < 128; k++) begin
            px(24'h600000 + 24'(k), wc);
            if (k == 127) wc128 = wc;
        end
        idle(140);
        check_burst("E", 128, 24'h600000, 24'h600000);
        if (cq.size() > 0) begin
            chk("E_latency", cq[0] - wc128, 32'd2);
            chk("E_first", {8'd0, dq[0]}, 32'h600000);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/raster_to_block.md
RASTER_TO_BLOCK -- requirements
Module: raster_to_block

Interface
REQ-001 Parameter WIDTH, default 1280, meaning pixels per line; SHALL be a multiple of 8.
REQ-002 Parameter HEIGHT, default 720, meaning lines per frame; SHALL be a multiple of 8.
REQ-003 Port pclk  input  1  single clock for all logic.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port in  input  dctPort_t  raster pixel stream; in.valid qualifies in.data (24 bit); no backpressure.
REQ-006 Port out  output  dctPort_t  pixel stream in 8x8 block order; out.valid qualifies out.data.
REQ-007 Port blkFirst  output  1  high with out.valid on pixel 0 of each block.
REQ-008 Port blkLast  output  1  high with out.valid on pixel 63 of each block.
REQ-009 Port frameLast  output  1  high with out.valid on the final pixel of the final block of a frame.
REQ-010 Port overflow  output  1  sticky error flag: a new 8-line band completed while the previous band was still being read.

Function
REQ-011 Storage SHALL be two banks (ping-pong), each holding 8*WIDTH pixels; band = 8 consecutive lines.
REQ-012 Write side: each in.valid writes in.data at address row*WIDTH+col of the write bank; col 0..WIDTH-1, then col->0, row+1.
REQ-013 When row 7, col WIDTH-1 is written: row->0, write bank toggles, band-ready pulse issued for the filled bank.
REQ-014 Frame line counter SHALL count 0..HEIGHT-1 and wrap to 0 after the last line; the band containing line HEIGHT-1 is tagged last-band.
REQ-015 Read FSM states: IDLE, READ. IDLE->READ on band-ready; READ->IDLE after the address of pixel 63 of block WIDTH/8-1 is issued.
REQ-016 In READ, one read address per cycle, ordered block bx=0..WIDTH/8-1, within block r=0..7, c=0..7; address = r*WIDTH + bx*8 + c.
REQ-017 RAM read latency SHALL be 1 cycle; out.valid and the flags SHALL be registered and asserted 2 cycles after the band-ready cycle for the first pixel, then on every consecutive cycle for 8*WIDTH cycles, gap-free.
REQ-018 blkFirst when r=0,c=0; blkLast when r=7,c=7; frameLast when blkLast, bx=WIDTH/8-1 and band tagged last-band; all flags delay-matched to out.data.
REQ-019 Write and read to different banks in the same cycle SHALL both proceed with no conflict.
REQ-020 If band-ready occurs while READ is active: overflow set (sticky until rst), current read continues to completion, the new band is not read.
REQ-021 out.data SHALL hold its last value when out.valid is low; only out.valid is guaranteed 0 outside bursts.

Reset
REQ-022 On rst: write col/row/line counters 0, write bank 0, FSM IDLE, read counters 0, out.valid/blkFirst/blkLast/frameLast/overflow 0.
REQ-023 Reset mid-band or mid-read SHALL discard all partial data; first in.valid after rst is treated as line 0, col 0 of a new frame.
REQ-024 RAM contents SHALL NOT require reset.

Structure
REQ-025 Shared package SHALL hold BLOCK_N=8 and the read FSM enum readState_t {IDLE, READ}; dctPort_t remains the existing shared type.
REQ-026 One sub-module, line_buf_ram: simple dual-port RAM, 2*8*WIDTH x 24, one write port, one synchronous read port, no reset.

Verification (WIDTH=16, HEIGHT=16 unless stated)
REQ-027 Dense input, pixel value = line*16+col for 128 pixels -> 128 outputs, first 8 = 0,1..7, 9th = 16, 64th = 119, 65th = 8; blkFirst at outputs 1 and 65, blkLast at 64 and 128.
REQ-028 in.valid 1-in-3 (DVP RGB888 rate), full frame of 256 pixels -> out.valid first asserted 2 cycles after the 128th input write; 4 blocks-bands total, frameLast only on output 256, overflow stays 0.
REQ-029 Two consecutive frames -> frameLast exactly twice, second-frame block 0 pixel 0 equals line 0 col 0 data of frame 2.
REQ-030 WIDTH=16, band completes and next band forced to complete while READ still active (test override of pacing via back-to-back bands with read stalled) -> overflow=1 and stays 1 until rst.
REQ-031 rst asserted after 70 input pixels, then 128 fresh pixels -> no output before the 128th fresh pixel; first output equals first fresh pixel; all outputs/flags 0 during rst.
